// File: rtl/stopwatch_lap_timer.sv
// Run/stop stopwatch (1/TICK_HZ s resolution) with a lap-capture FIFO.
// Countdown mode, time load and o_expired exist only with STOPWATCH_COUNTDOWN_EN defined.
module stopwatch_lap_timer #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 100,
  parameter int HOUR_MAX  = 24,
  parameter int LAP_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_run,
  input  logic                        i_stop,
  input  logic                        i_clear,
  input  logic                        i_lap,
  input  logic                        i_lap_rd,
  input  logic                        i_mode_down,
  input  logic                        i_load,
  input  logic [6:0]                  i_ld_msec,
  input  logic [5:0]                  i_ld_sec,
  input  logic [5:0]                  i_ld_min,
  input  logic [4:0]                  i_ld_hour,
  output logic                        o_is_running,
  output logic [6:0]                  msec,
  output logic [5:0]                  sec,
  output logic [5:0]                  min,
  output logic [4:0]                  hour,
  output logic                        o_expired,
  output logic                        o_lap_valid,
  output logic [6:0]                  o_lap_msec,
  output logic [5:0]                  o_lap_sec,
  output logic [5:0]                  o_lap_min,
  output logic [4:0]                  o_lap_hour,
  output logic [$clog2(LAP_DEPTH):0]  o_lap_count,
  output logic                        o_lap_ovf
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(LAP_DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
  localparam logic [6:0]    MSEC_MAX = 7'(TICK_HZ - 1);
  localparam logic [5:0]    SEC_MAX  = 6'd59;
  localparam logic [4:0]    HOUR_TOP = 5'(HOUR_MAX - 1);
  localparam logic [CW-1:0] FULL     = CW'(LAP_DEPTH);
  localparam logic [1:0]    S_IDLE = 2'd0, S_RUN = 2'd1, S_STOP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    msec_q, msec_d, up_msec;
  logic [5:0]    sec_q, sec_d, up_sec;
  logic [5:0]    min_q, min_d, up_min;
  logic [4:0]    hour_q, hour_d, up_hour;
  logic          tick_s;
  logic [23:0]   lap_mem_q [LAP_DEPTH];
  logic [23:0]   lap_mem_d [LAP_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d, push_s, pop_s, wr_ok_s;
  logic [23:0]   head_s;

  assign tick_s = (state_q == S_RUN) && (presc_q == PRE_MAX);

  // Next time value when counting up, with cascaded carries
  always_comb begin
    up_msec = msec_q;
    up_sec  = sec_q;
    up_min  = min_q;
    up_hour = hour_q;
    if (msec_q == MSEC_MAX) begin
      up_msec = 7'd0;
      if (sec_q == SEC_MAX) begin
        up_sec = 6'd0;
        if (min_q == SEC_MAX) begin
          up_min  = 6'd0;
          up_hour = (hour_q == HOUR_TOP) ? 5'd0 : hour_q + 5'd1;
        end else begin
          up_min = min_q + 6'd1;
        end
      end else begin
        up_sec = sec_q + 6'd1;
      end
    end else begin
      up_msec = msec_q + 7'd1;
    end
  end

`ifdef STOPWATCH_COUNTDOWN_EN
  logic       mode_q, mode_d, expired_q, expired_d, zero_s;
  logic [6:0] dn_msec, ld_msec_s;
  logic [5:0] dn_sec, dn_min, ld_sec_s, ld_min_s;
  logic [4:0] dn_hour, ld_hour_s;

  assign zero_s    = (msec_q == 7'd0) && (sec_q == 6'd0) && (min_q == 6'd0) && (hour_q == 5'd0);
  assign ld_msec_s = (i_ld_msec > MSEC_MAX) ? MSEC_MAX : i_ld_msec;
  assign ld_sec_s  = (i_ld_sec > SEC_MAX) ? SEC_MAX : i_ld_sec;
  assign ld_min_s  = (i_ld_min > SEC_MAX) ? SEC_MAX : i_ld_min;
  assign ld_hour_s = (i_ld_hour > HOUR_TOP) ? HOUR_TOP : i_ld_hour;
  assign o_expired = expired_q;

  // Next time value when counting down; only used while the time is non-zero
  always_comb begin
    dn_msec = msec_q;
    dn_sec  = sec_q;
    dn_min  = min_q;
    dn_hour = hour_q;
    if (msec_q == 7'd0) begin
      dn_msec = MSEC_MAX;
      if (sec_q == 6'd0) begin
        dn_sec = SEC_MAX;
        if (min_q == 6'd0) begin
          dn_min  = SEC_MAX;
          dn_hour = hour_q - 5'd1;
        end else begin
          dn_min = min_q - 6'd1;
        end
      end else begin
        dn_sec = sec_q - 6'd1;
      end
    end else begin
      dn_msec = msec_q - 7'd1;
    end
  end

  // Mode and expiry pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      expired_q <= expired_d;
    end
  end
`else
  logic unused_ld_s;
  assign unused_ld_s = ^{i_mode_down, i_load, i_ld_msec, i_ld_sec, i_ld_min, i_ld_hour};
  assign o_expired   = 1'b0;
`endif

  // FSM, prescaler and live time next-state
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    {hour_d, min_d, sec_d, msec_d} = {hour_q, min_q, sec_q, msec_q};
`ifdef STOPWATCH_COUNTDOWN_EN
    expired_d = 1'b0;
    if (state_q != S_RUN) mode_d = i_mode_down;
    else                  mode_d = mode_q;
`endif
    if (i_clear) begin
      state_d = S_IDLE;
      presc_d = '0;
      {hour_d, min_d, sec_d, msec_d} = 24'd0;
    end else begin
      if (state_q == S_RUN) presc_d = tick_s ? '0 : presc_q + PW'(1);
      else                  presc_d = presc_q;
      case (state_q)
        S_IDLE:  state_d = i_run ? S_RUN : S_IDLE;
        S_RUN:   state_d = i_stop ? S_STOP : S_RUN;
        S_STOP:  state_d = (i_run && !i_stop) ? S_RUN : S_STOP;
        default: state_d = S_IDLE;
      endcase
      if (tick_s) begin
`ifdef STOPWATCH_COUNTDOWN_EN
        if (!mode_q) begin
          {hour_d, min_d, sec_d, msec_d} = {up_hour, up_min, up_sec, up_msec};
        end else if (zero_s) begin
          // expiry: time already zero, hold it there and pause
          expired_d = 1'b1;
          state_d   = S_STOP;
        end else begin
          {hour_d, min_d, sec_d, msec_d} = {dn_hour, dn_min, dn_sec, dn_msec};
        end
`else
        {hour_d, min_d, sec_d, msec_d} = {up_hour, up_min, up_sec, up_msec};
`endif
      end else begin
        presc_d = presc_d;
      end
`ifdef STOPWATCH_COUNTDOWN_EN
      if (i_load && (state_q != S_RUN)) begin
        presc_d = '0;
        {hour_d, min_d, sec_d, msec_d} = {ld_hour_s, ld_min_s, ld_sec_s, ld_msec_s};
      end else begin
        presc_d = presc_d;
      end
`endif
    end
  end

  // Lap FIFO next-state; a pop frees the slot a same-cycle push needs when full
  always_comb begin
    lap_mem_d = lap_mem_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    push_s    = i_lap && (state_q == S_RUN) && !i_clear;
    pop_s     = i_lap_rd && (cnt_q != '0) && !i_clear;
    wr_ok_s   = push_s && ((cnt_q != FULL) || pop_s);
    if (i_clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (wr_ok_s) begin
        lap_mem_d[wr_q] = {hour_q, min_q, sec_q, msec_q};
        wr_d = wr_q + AW'(1);
      end else if (push_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
      if (pop_s) rd_d = rd_q + AW'(1);
      else       rd_d = rd_q;
      case ({wr_ok_s, pop_s})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      msec_q  <= 7'd0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hour_q  <= 5'd0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++) lap_mem_q[i] <= 24'd0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      msec_q    <= msec_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      lap_mem_q <= lap_mem_d;
    end
  end

  assign head_s       = lap_mem_q[rd_q];
  assign o_is_running = (state_q == S_RUN);
  assign {hour, min, sec, msec} = {hour_q, min_q, sec_q, msec_q};
  assign o_lap_valid  = (cnt_q != '0);
  assign o_lap_count  = cnt_q;
  assign o_lap_ovf    = ovf_q;
  assign {o_lap_hour, o_lap_min, o_lap_sec, o_lap_msec} = o_lap_valid ? head_s : 24'd0;
endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Randomised self-checking bench for stopwatch_lap_timer; the model keeps time as a
// single count of hundredths and the FIFO as a queue.
module tb_stopwatch_lap_timer;
  localparam int DIV = 10, MOD = 24 * 360000;
  localparam int IDLE = 0, RUN = 1, STOP = 2;

  logic clk, rst, i_run, i_stop, i_clear, i_lap, i_lap_rd, i_mode_down, i_load;
  logic [6:0] i_ld_msec, msec, o_lap_msec;
  logic [5:0] i_ld_sec, i_ld_min, sec, min, o_lap_sec, o_lap_min;
  logic [4:0] i_ld_hour, hour, o_lap_hour;
  logic o_is_running, o_expired, o_lap_valid, o_lap_ovf;
  logic [2:0] o_lap_count;
  logic [23:0] dut_t, dut_head;

  int total, bad;
  int m_st, m_t, m_ph;
  bit m_mode, m_exp, m_ovf;
  int m_q[$];

  stopwatch_lap_timer #(.CLK_HZ(1000), .TICK_HZ(100), .HOUR_MAX(24), .LAP_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .i_run(i_run), .i_stop(i_stop), .i_clear(i_clear), .i_lap(i_lap),
    .i_lap_rd(i_lap_rd), .i_mode_down(i_mode_down), .i_load(i_load), .i_ld_msec(i_ld_msec),
    .i_ld_sec(i_ld_sec), .i_ld_min(i_ld_min), .i_ld_hour(i_ld_hour), .o_is_running(o_is_running),
    .msec(msec), .sec(sec), .min(min), .hour(hour), .o_expired(o_expired), .o_lap_valid(o_lap_valid),
    .o_lap_msec(o_lap_msec), .o_lap_sec(o_lap_sec), .o_lap_min(o_lap_min), .o_lap_hour(o_lap_hour),
    .o_lap_count(o_lap_count), .o_lap_ovf(o_lap_ovf));

  assign dut_t    = {hour, min, sec, msec};
  assign dut_head = {o_lap_hour, o_lap_min, o_lap_sec, o_lap_msec};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] fields(input int t);
    return {5'(t / 360000), 6'((t / 6000) % 60), 6'((t / 100) % 60), 7'(t % 100)};
  endfunction

  function automatic int ld_total();
    int ms, s, mi, h;
    ms = (int'(i_ld_msec) > 99) ? 99 : int'(i_ld_msec);
    s  = (int'(i_ld_sec) > 59) ? 59 : int'(i_ld_sec);
    mi = (int'(i_ld_min) > 59) ? 59 : int'(i_ld_min);
    h  = (int'(i_ld_hour) > 23) ? 23 : int'(i_ld_hour);
    return h * 360000 + mi * 6000 + s * 100 + ms;
  endfunction

  task automatic model_reset();
    m_st = IDLE; m_t = 0; m_ph = 0; m_mode = 1'b0; m_exp = 1'b0; m_ovf = 1'b0;
    m_q.delete();
  endtask

  // Reference behaviour for one clock edge, using the inputs currently driven
  task automatic model_step();
    int st0;
    bit tick;
    st0 = m_st;
    m_exp = 1'b0;
    if (i_clear) begin
      m_st = IDLE; m_t = 0; m_ph = 0; m_ovf = 1'b0;
      m_q.delete();
    end else begin
      if (i_lap_rd && m_q.size() > 0) void'(m_q.pop_front());
      if (i_lap && st0 == RUN) begin
        if (m_q.size() < 4) m_q.push_back(m_t);
        else m_ovf = 1'b1;
      end
      tick = (st0 == RUN) && (m_ph == DIV - 1);
      if (st0 == RUN) m_ph = tick ? 0 : m_ph + 1;
      if (st0 == IDLE && i_run) m_st = RUN;
      if (st0 == RUN && i_stop) m_st = STOP;
      if (st0 == STOP && i_run && !i_stop) m_st = RUN;
      if (tick) begin
        if (!m_mode) m_t = (m_t + 1) % MOD;
        else if (m_t == 0) begin m_exp = 1'b1; m_st = STOP; end
        else m_t = m_t - 1;
      end
`ifdef STOPWATCH_COUNTDOWN_EN
      if (i_load && st0 != RUN) begin m_ph = 0; m_t = ld_total(); end
`endif
    end
`ifdef STOPWATCH_COUNTDOWN_EN
    if (st0 != RUN) m_mode = i_mode_down;
`endif
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    i_run = 1'b0; i_stop = 1'b0; i_clear = 1'b0; i_lap = 1'b0; i_lap_rd = 1'b0; i_load = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (dut_t !== 24'd0 || o_is_running !== 1'b0 || o_expired !== 1'b0) begin
      bad++; $display("FAIL reset_time: got t=%h run=%b exp=%b, want 0", dut_t, o_is_running, o_expired); end
    total++; if (o_lap_valid !== 1'b0 || o_lap_count !== 3'd0 || o_lap_ovf !== 1'b0 || dut_head !== 24'd0) begin
      bad++; $display("FAIL reset_fifo: got v=%b c=%0d o=%b h=%h, want 0", o_lap_valid, o_lap_count, o_lap_ovf, dut_head); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_run_stop();
    i_run = 1'b1; step();
    repeat (995) step();
    total++; if (msec !== 7'd99 || sec !== 6'd0) begin
      bad++; $display("FAIL rs_995: got sec=%0d msec=%0d, want 0/99", sec, msec); end
    total++; if (dut_t !== fields(m_t)) begin
      bad++; $display("FAIL rs_model: got %h, want %h", dut_t, fields(m_t)); end
    repeat (5) step();
    total++; if (dut_t !== {5'd0, 6'd0, 6'd1, 7'd0}) begin
      bad++; $display("FAIL rs_1000: got %h, want 0:0:1:0", dut_t); end
    i_stop = 1'b1; step();
    repeat (100) step();
    total++; if (dut_t !== {5'd0, 6'd0, 6'd1, 7'd0} || o_is_running !== 1'b0) begin
      bad++; $display("FAIL rs_frozen: got %h run=%b, want 0:0:1:0 run=0", dut_t, o_is_running); end
    i_run = 1'b1; step();
    repeat (8) step();
    total++; if (dut_t !== {5'd0, 6'd0, 6'd1, 7'd0} || o_is_running !== 1'b1) begin
      bad++; $display("FAIL rs_phase_early: got %h run=%b, want 0:0:1:0 run=1", dut_t, o_is_running); end
    step();
    total++; if (dut_t !== {5'd0, 6'd0, 6'd1, 7'd1}) begin
      bad++; $display("FAIL rs_phase: got %h, want 0:0:1:1", dut_t); end
  endtask

  task automatic test_lap();
    int cap[5];
    i_clear = 1'b1; step();
    i_run = 1'b1; step();
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(3, 25)) step();
      cap[i] = m_t; i_lap = 1'b1; step();
    end
    total++; if (o_lap_count !== 3'd4 || o_lap_ovf !== 1'b1 || dut_head !== fields(cap[0])) begin
      bad++; $display("FAIL lap_ovf: got c=%0d o=%b h=%h, want 4/1/%h", o_lap_count, o_lap_ovf, dut_head, fields(cap[0])); end
    for (int k = 0; k < 4; k++) begin
      total++; if (o_lap_valid !== 1'b1 || dut_head !== fields(cap[k])) begin
        bad++; $display("FAIL lap_order%0d: got v=%b h=%h, want 1/%h", k, o_lap_valid, dut_head, fields(cap[k])); end
      i_lap_rd = 1'b1; step();
    end
    total++; if (o_lap_valid !== 1'b0 || o_lap_count !== 3'd0) begin
      bad++; $display("FAIL lap_empty: got v=%b c=%0d, want 0/0", o_lap_valid, o_lap_count); end
    i_clear = 1'b1; step();
    i_run = 1'b1; step();
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(3, 25)) step();
      cap[i] = m_t; i_lap = 1'b1; step();
    end
    total++; if (o_lap_count !== 3'd4 || o_lap_ovf !== 1'b0) begin
      bad++; $display("FAIL lap_full: got c=%0d o=%b, want 4/0", o_lap_count, o_lap_ovf); end
    repeat (5) step();
    cap[0] = m_t; i_lap = 1'b1; i_lap_rd = 1'b1; step();
    total++; if (o_lap_count !== 3'd4 || o_lap_ovf !== 1'b0 || dut_head !== fields(cap[1])) begin
      bad++; $display("FAIL lap_pushpop: got c=%0d o=%b h=%h, want 4/0/%h", o_lap_count, o_lap_ovf, dut_head, fields(cap[1])); end
    for (int k = 1; k < 5; k++) begin
      total++; if (dut_head !== fields(cap[k % 4 == 0 ? 0 : k])) begin
        bad++; $display("FAIL lap_order_b%0d: got %h, want %h", k, dut_head, fields(cap[k % 4 == 0 ? 0 : k])); end
      i_lap_rd = 1'b1; step();
    end
  endtask

  task automatic test_priority();
    i_clear = 1'b1; step();
    i_run = 1'b1; step();
    repeat (15) step();
    repeat (5) begin i_lap = 1'b1; step(); step(); end
    i_clear = 1'b1; i_stop = 1'b1; i_run = 1'b1; step();
    total++; if (o_is_running !== 1'b0 || dut_t !== 24'd0 || o_lap_count !== 3'd0 || o_lap_valid !== 1'b0 || o_lap_ovf !== 1'b0) begin
      bad++; $display("FAIL prio_clear: got run=%b t=%h c=%0d v=%b o=%b, want all 0", o_is_running, dut_t, o_lap_count, o_lap_valid, o_lap_ovf); end
    repeat (20) step();
    total++; if (dut_t !== 24'd0 || o_is_running !== 1'b0) begin
      bad++; $display("FAIL prio_idle: got t=%h run=%b, want 0/0", dut_t, o_is_running); end
  endtask

`ifdef STOPWATCH_COUNTDOWN_EN
  task automatic test_countdown();
    i_clear = 1'b1; step();
    i_mode_down = 1'b1; i_load = 1'b1;
    i_ld_hour = 5'd0; i_ld_min = 6'd0; i_ld_sec = 6'd1; i_ld_msec = 7'd2; step();
    total++; if (dut_t !== {5'd0, 6'd0, 6'd1, 7'd2}) begin
      bad++; $display("FAIL cd_load: got %h, want 0:0:1:2", dut_t); end
    i_run = 1'b1; step();
    repeat (30) step();
    total++; if (dut_t !== {5'd0, 6'd0, 6'd0, 7'd99}) begin
      bad++; $display("FAIL cd_3ticks: got %h, want 0:0:0:99", dut_t); end
    repeat (999) step();
    total++; if (o_is_running !== 1'b1 || o_expired !== 1'b0 || dut_t !== 24'd0) begin
      bad++; $display("FAIL cd_pre: got run=%b exp=%b t=%h, want 1/0/0", o_is_running, o_expired, dut_t); end
    step();
    total++; if (o_is_running !== 1'b0 || o_expired !== 1'b1 || dut_t !== 24'd0) begin
      bad++; $display("FAIL cd_expire: got run=%b exp=%b t=%h, want 0/1/0", o_is_running, o_expired, dut_t); end
    step();
    total++; if (o_expired !== 1'b0) begin
      bad++; $display("FAIL cd_pulse: got exp=%b, want 0", o_expired); end
    i_mode_down = 1'b0; i_load = 1'b1;
    i_ld_hour = 5'd31; i_ld_min = 6'd63; i_ld_sec = 6'd63; i_ld_msec = 7'd127; step();
    total++; if (dut_t !== {5'd23, 6'd59, 6'd59, 7'd99}) begin
      bad++; $display("FAIL cd_sat: got %h, want 23:59:59:99", dut_t); end
    i_run = 1'b1; step();
    repeat (10) step();
    total++; if (dut_t !== 24'd0 || o_expired !== 1'b0 || o_is_running !== 1'b1) begin
      bad++; $display("FAIL up_rollover: got t=%h exp=%b run=%b, want 0/0/1", dut_t, o_expired, o_is_running); end
  endtask
`else
  task automatic test_load_ignored();
    i_clear = 1'b1; step();
    i_mode_down = 1'b1; i_load = 1'b1;
    i_ld_hour = 5'd3; i_ld_min = 6'd4; i_ld_sec = 6'd5; i_ld_msec = 7'd6; step();
    total++; if (dut_t !== 24'd0) begin
      bad++; $display("FAIL load_ignored: got %h, want 0", dut_t); end
    i_run = 1'b1; step();
    repeat (10) step();
    total++; if (dut_t !== {5'd0, 6'd0, 6'd0, 7'd1} || o_expired !== 1'b0) begin
      bad++; $display("FAIL up_only: got t=%h exp=%b, want 0:0:0:1/0", dut_t, o_expired); end
    i_mode_down = 1'b0;
  endtask
`endif

  task automatic test_async_reset();
    i_clear = 1'b1; step();
    i_run = 1'b1; step();
    repeat ($urandom_range(13, 50)) step();
    i_lap = 1'b1; step();
    #3 rst = 1'b1;
    #1;
    total++; if (dut_t !== 24'd0 || o_is_running !== 1'b0 || o_lap_count !== 3'd0 || o_lap_valid !== 1'b0 || dut_head !== 24'd0) begin
      bad++; $display("FAIL async_rst: got t=%h run=%b c=%0d v=%b h=%h, want all 0", dut_t, o_is_running, o_lap_count, o_lap_valid, dut_head); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    i_lap = 1'b1; step();
    total++; if (o_lap_count !== 3'd0 || o_lap_valid !== 1'b0) begin
      bad++; $display("FAIL lap_idle: got c=%0d v=%b, want 0/0", o_lap_count, o_lap_valid); end
    repeat (20) step();
    total++; if (dut_t !== 24'd0 || o_is_running !== 1'b0) begin
      bad++; $display("FAIL rst_idle: got t=%h run=%b, want 0/0", dut_t, o_is_running); end
  endtask

  task automatic test_random();
    bit ev;
    i_clear = 1'b1; step();
    for (int n = 0; n < 3000; n++) begin
      i_run    = ($urandom_range(0, 19) == 0);
      i_stop   = ($urandom_range(0, 39) == 0);
      if (i_stop) i_run = 1'b0;
      i_clear  = ($urandom_range(0, 299) == 0);
      i_lap    = ($urandom_range(0, 9) == 0);
      i_lap_rd = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 99) == 0) i_mode_down = ~i_mode_down;
      i_load = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 0) begin
        i_ld_hour = 5'd0; i_ld_min = 6'd0; i_ld_sec = 6'($urandom_range(0, 1)); i_ld_msec = 7'($urandom_range(0, 20));
      end else begin
        i_ld_hour = 5'($urandom); i_ld_min = 6'($urandom); i_ld_sec = 6'($urandom); i_ld_msec = 7'($urandom);
      end
      step();
      total++; if (dut_t !== fields(m_t)) begin
        bad++; $display("FAIL rnd_time@%0d: got %h, want %h", n, dut_t, fields(m_t)); end
      total++; if (o_is_running !== (m_st == RUN) || o_expired !== m_exp) begin
        bad++; $display("FAIL rnd_state@%0d: got run=%b exp=%b, want %b/%b", n, o_is_running, o_expired, m_st == RUN, m_exp); end
      total++; if (o_lap_count !== 3'(m_q.size()) || o_lap_ovf !== m_ovf) begin
        bad++; $display("FAIL rnd_fifo@%0d: got c=%0d o=%b, want %0d/%b", n, o_lap_count, o_lap_ovf, m_q.size(), m_ovf); end
      ev = (m_q.size() > 0);
      total++; if (o_lap_valid !== ev || (ev && dut_head !== fields(m_q[0]))) begin
        bad++; $display("FAIL rnd_head@%0d: got v=%b h=%h, want %b/%h", n, o_lap_valid, dut_head, ev, ev ? fields(m_q[0]) : 24'd0); end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    i_run = 1'b0; i_stop = 1'b0; i_clear = 1'b0; i_lap = 1'b0; i_lap_rd = 1'b0;
    i_mode_down = 1'b0; i_load = 1'b0;
    i_ld_msec = 7'd0; i_ld_sec = 6'd0; i_ld_min = 6'd0; i_ld_hour = 5'd0;
    model_reset();
    test_reset();
    test_run_stop();
    test_lap();
    test_priority();
`ifdef STOPWATCH_COUNTDOWN_EN
    test_countdown();
`else
    test_load_ignored();
`endif
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
